// File: rtl/router_reg.sv
// rtl/router_reg.sv - datapath register block of the 1x3 packet router
//
// Captures the packet header (source, destination, size) under the router
// FSM's one-hot strobes. Forwards header and payload bytes to the FIFO
// stage, and keeps a running XOR checksum over the payload.
//
// Ports:
//   clk1            in   single clock, rising edge
//   reset           in   synchronous, active-high
//   packet_valid_i  in   packet_in carries a valid byte this cycle
//   packet_in[7:0]  in   incoming packet byte
//   get_source, get_dest, store_header, get_size, load_data, get_crc
//                   in   FSM state strobes (one-hot)
//   fifo_full       in   downstream FIFO cannot accept a byte this cycle
//   full_state      in   FSM is in the FIFO-full recovery state
//   dsize[2:0]      out  payload byte count from the size byte
//   data_out[7:0]   out  byte presented to the FIFO
//   destination[7:0] out latched destination byte
//   crc_checked     out  checksum comparison done for the current packet
//   trusted_source  out  latched source is in the trusted range 0x80-0xFF
//   err             out  checksum or length mismatch in the current packet

module router_reg (
  input  logic       clk1,
  input  logic       reset,
  input  logic       packet_valid_i,
  input  logic [7:0] packet_in,
  input  logic       get_source,
  input  logic       get_dest,
  input  logic       store_header,
  input  logic       get_size,
  input  logic       load_data,
  input  logic       get_crc,
  input  logic       fifo_full,
  input  logic       full_state,
  output logic [2:0] dsize,
  output logic [7:0] data_out,
  output logic [7:0] destination,
  output logic       crc_checked,
  output logic       trusted_source,
  output logic       err
);

  logic [7:0] source;
  logic [7:0] chk;
  logic [2:0] cnt;
  logic [7:0] hold;
  logic       hold_valid;

  // The if/else-if chain encodes strobe priority in case the FSM ever
  // drives more than one strobe at once.
  always_ff @(posedge clk1) begin
    if (reset) begin
      source         <= 8'h00;
      chk            <= 8'h00;
      cnt            <= 3'd0;
      hold           <= 8'h00;
      hold_valid     <= 1'b0;
      dsize          <= 3'd0;
      data_out       <= 8'h00;
      destination    <= 8'h00;
      crc_checked    <= 1'b0;
      trusted_source <= 1'b0;
      err            <= 1'b0;
    end else if (full_state) begin
      // Drain the byte that was blocked while the FIFO was full.
      if (!fifo_full && hold_valid) begin
        data_out   <= hold;
        hold_valid <= 1'b0;
      end
    end else if (get_source) begin
      if (packet_valid_i) begin
        source         <= packet_in;
        trusted_source <= packet_in[7];
        chk            <= 8'h00;
        cnt            <= 3'd0;
        crc_checked    <= 1'b0;
        err            <= 1'b0;
        hold_valid     <= 1'b0;
      end
    end else if (get_dest) begin
      if (packet_valid_i) begin
        destination <= packet_in;
      end
    end else if (store_header) begin
      data_out <= destination;
    end else if (get_size) begin
      if (packet_valid_i) begin
        dsize <= packet_in[2:0];
      end
    end else if (load_data) begin
      if (packet_valid_i) begin
        chk <= chk ^ packet_in;
        cnt <= cnt + 3'd1;
        if (fifo_full) begin
          hold       <= packet_in;
          hold_valid <= 1'b1;
        end else begin
          data_out <= packet_in;
        end
      end
    end else if (get_crc) begin
      if (packet_valid_i) begin
        crc_checked <= 1'b1;
        err         <= (packet_in != chk) || (cnt != dsize);
      end
    end
  end

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - directed self-checking bench for router_reg

module tb_router_reg;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       packet_valid_i;
  logic [7:0] packet_in;
  logic       get_source, get_dest, store_header, get_size, load_data, get_crc;
  logic       fifo_full, full_state;
  logic [2:0] dsize;
  logic [7:0] data_out, destination;
  logic       crc_checked, trusted_source, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Strobe vector layout: {full_state, get_source, get_dest, store_header, get_size, load_data, get_crc}
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_FULL = 7'b1000000;
  localparam logic [6:0] S_SRC  = 7'b0100000;
  localparam logic [6:0] S_DST  = 7'b0010000;
  localparam logic [6:0] S_HDR  = 7'b0001000;
  localparam logic [6:0] S_SIZE = 7'b0000100;
  localparam logic [6:0] S_DATA = 7'b0000010;
  localparam logic [6:0] S_CRC  = 7'b0000001;

  router_reg dut (
    .clk1(clk1), .reset(reset), .packet_valid_i(packet_valid_i), .packet_in(packet_in),
    .get_source(get_source), .get_dest(get_dest), .store_header(store_header),
    .get_size(get_size), .load_data(load_data), .get_crc(get_crc),
    .fifo_full(fifo_full), .full_state(full_state),
    .dsize(dsize), .data_out(data_out), .destination(destination),
    .crc_checked(crc_checked), .trusted_source(trusted_source), .err(err)
  );

  always #5 clk1 = ~clk1;

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic [6:0] s, input logic v, input logic [7:0] d, input logic ff);
    {full_state, get_source, get_dest, store_header, get_size, load_data, get_crc} = s;
    packet_valid_i = v;
    packet_in = d;
    fifo_full = ff;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(S_SRC, 1'b1, 8'hFF, 1'b0);
      total_cnt++; if ({dsize, data_out, destination, crc_checked, trusted_source, err} !== 22'd0) $display("FAIL reset_outputs cycle %0d: got %h/%h/%h/%b/%b/%b want all 0", i, dsize, data_out, destination, crc_checked, trusted_source, err); else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  task automatic test_packet1;
    step(S_SRC, 1'b1, 8'h81, 1'b0);
    total_cnt++; if (trusted_source !== 1'b1) $display("FAIL p1_trusted: got %b want 1", trusted_source); else pass_cnt++;
    step(S_DST, 1'b1, 8'h0F, 1'b0);
    total_cnt++; if (destination !== 8'h0F) $display("FAIL p1_dest: got %h want 0f", destination); else pass_cnt++;
    step(S_HDR, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (data_out !== 8'h0F) $display("FAIL p1_header_fwd: got %h want 0f", data_out); else pass_cnt++;
    step(S_SIZE, 1'b1, 8'h02, 1'b0);
    total_cnt++; if (dsize !== 3'd2) $display("FAIL p1_dsize: got %0d want 2", dsize); else pass_cnt++;
    step(S_DATA, 1'b1, 8'hF0, 1'b0);
    total_cnt++; if (data_out !== 8'hF0) $display("FAIL p1_data0: got %h want f0", data_out); else pass_cnt++;
    step(S_DATA, 1'b1, 8'h0F, 1'b0);
    total_cnt++; if (data_out !== 8'h0F) $display("FAIL p1_data1: got %h want 0f", data_out); else pass_cnt++;
    step(S_CRC, 1'b1, 8'hFF, 1'b0);
    total_cnt++; if ({crc_checked, err} !== 2'b10) $display("FAIL p1_crc: got chk=%b err=%b want 1/0", crc_checked, err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    // First-packet status still visible going into this get_source cycle.
    total_cnt++; if (crc_checked !== 1'b1) $display("FAIL b2b_status_visible: got %b want 1", crc_checked); else pass_cnt++;
    step(S_SRC, 1'b1, 8'h18, 1'b0);
    total_cnt++; if ({trusted_source, crc_checked, err} !== 3'b000) $display("FAIL p2_src_clear: got %b%b%b want 000", trusted_source, crc_checked, err); else pass_cnt++;
    step(S_DST, 1'b1, 8'h0A, 1'b0);
    step(S_SIZE, 1'b1, 8'h03, 1'b0);
    total_cnt++; if (dsize !== 3'd3) $display("FAIL p2_dsize: got %0d want 3", dsize); else pass_cnt++;
    step(S_DATA, 1'b1, 8'hF0, 1'b0);
    step(S_DATA, 1'b1, 8'h0F, 1'b0);
    step(S_DATA, 1'b1, 8'h3E, 1'b0);
    total_cnt++; if (data_out !== 8'h3E) $display("FAIL p2_data2: got %h want 3e", data_out); else pass_cnt++;
    step(S_CRC, 1'b1, 8'hFF, 1'b0);
    total_cnt++; if ({crc_checked, err} !== 2'b11) $display("FAIL p2_crc_err: got chk=%b err=%b want 1/1", crc_checked, err); else pass_cnt++;
  endtask

  task automatic test_length_mismatch;
    step(S_SRC, 1'b1, 8'h90, 1'b0);
    step(S_DST, 1'b1, 8'h02, 1'b0);
    step(S_SIZE, 1'b1, 8'h02, 1'b0);
    step(S_DATA, 1'b1, 8'h01, 1'b0);
    step(S_DATA, 1'b1, 8'h02, 1'b0);
    step(S_DATA, 1'b1, 8'h04, 1'b0);
    step(S_CRC, 1'b1, 8'h07, 1'b0);
    total_cnt++; if ({crc_checked, err} !== 2'b11) $display("FAIL len_mismatch: got chk=%b err=%b want 1/1", crc_checked, err); else pass_cnt++;
  endtask

  task automatic test_fifo_full;
    step(S_SRC, 1'b1, 8'h85, 1'b0);
    step(S_DST, 1'b1, 8'h01, 1'b0);
    step(S_SIZE, 1'b1, 8'h02, 1'b0);
    step(S_DATA, 1'b1, 8'h3C, 1'b0);
    total_cnt++; if (data_out !== 8'h3C) $display("FAIL ff_first: got %h want 3c", data_out); else pass_cnt++;
    step(S_DATA, 1'b1, 8'hA5, 1'b1);
    total_cnt++; if (data_out !== 8'h3C) $display("FAIL ff_blocked: got %h want 3c", data_out); else pass_cnt++;
    step(S_FULL, 1'b0, 8'h00, 1'b1);
    total_cnt++; if (data_out !== 8'h3C) $display("FAIL ff_still_full: got %h want 3c", data_out); else pass_cnt++;
    step(S_FULL, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (data_out !== 8'hA5) $display("FAIL ff_drain: got %h want a5", data_out); else pass_cnt++;
    // 0x3C ^ 0xA5 = 0x99
    step(S_CRC, 1'b1, 8'h99, 1'b0);
    total_cnt++; if ({crc_checked, err} !== 2'b10) $display("FAIL ff_crc: got chk=%b err=%b want 1/0", crc_checked, err); else pass_cnt++;
    // full_state outranks get_source: trusted_source must not change.
    step(S_FULL | S_SRC, 1'b1, 8'h00, 1'b0);
    total_cnt++; if ({trusted_source, crc_checked} !== 2'b11) $display("FAIL priority_full_over_src: got %b%b want 11", trusted_source, crc_checked); else pass_cnt++;
  endtask

  task automatic test_valid_low;
    step(S_SRC, 1'b1, 8'h01, 1'b0);
    step(S_DST, 1'b1, 8'h22, 1'b0);
    step(S_DST, 1'b0, 8'h55, 1'b0);
    total_cnt++; if (destination !== 8'h22) $display("FAIL vl_dest: got %h want 22", destination); else pass_cnt++;
    step(S_SIZE, 1'b1, 8'h01, 1'b0);
    step(S_DATA, 1'b1, 8'h44, 1'b0);
    step(S_DATA, 1'b0, 8'h77, 1'b0);
    total_cnt++; if (data_out !== 8'h44) $display("FAIL vl_data: got %h want 44", data_out); else pass_cnt++;
    // chk and cnt must be unaffected by the invalid byte.
    step(S_CRC, 1'b1, 8'h44, 1'b0);
    total_cnt++; if ({trusted_source, crc_checked, err} !== 3'b010) $display("FAIL vl_crc: got %b%b%b want 010", trusted_source, crc_checked, err); else pass_cnt++;
  endtask

  task automatic test_zero_size;
    step(S_SRC, 1'b1, 8'hFF, 1'b0);
    step(S_DST, 1'b1, 8'h03, 1'b0);
    step(S_SIZE, 1'b1, 8'hF8, 1'b0);
    total_cnt++; if (dsize !== 3'd0) $display("FAIL zs_dsize: got %0d want 0", dsize); else pass_cnt++;
    step(S_CRC, 1'b1, 8'h00, 1'b0);
    total_cnt++; if ({crc_checked, err} !== 2'b10) $display("FAIL zs_crc: got chk=%b err=%b want 1/0", crc_checked, err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet;
    step(S_SRC, 1'b1, 8'h80, 1'b0);
    step(S_DST, 1'b1, 8'h09, 1'b0);
    step(S_SIZE, 1'b1, 8'h02, 1'b0);
    step(S_DATA, 1'b1, 8'h12, 1'b0);
    reset = 1'b1;
    step(S_DATA, 1'b1, 8'h34, 1'b0);
    reset = 1'b0;
    total_cnt++; if ({dsize, data_out, destination, crc_checked, trusted_source, err} !== 22'd0) $display("FAIL reset_mid: got %h/%h/%h/%b/%b/%b want all 0", dsize, data_out, destination, crc_checked, trusted_source, err); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    {full_state, get_source, get_dest, store_header, get_size, load_data, get_crc} = S_NONE;
    packet_valid_i = 1'b0;
    packet_in = 8'h00;
    fifo_full = 1'b0;
    test_reset;
    test_packet1;
    test_back_to_back;
    test_length_mismatch;
    test_fifo_full;
    test_valid_low;
    test_zero_size;
    test_reset_mid_packet;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register block of the 1x3 packet router. Under control of the router FSM's one-hot state strobes, it captures the packet header (source, destination, size). It forwards header and payload bytes toward the synchronizer/FIFO stage, computes an XOR checksum over the payload, and reports source trust, checksum completion and packet error.

## Interface
Parameters: none.
- clk1  input  1  single clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- packet_valid_i  input  1  packet_in carries a valid byte this cycle.
- packet_in  input  8  incoming packet byte.
- get_source, get_dest, store_header, get_size, load_data, get_crc  input  1 each  FSM state strobes, one-hot.
- fifo_full  input  1  downstream FIFO cannot accept a byte this cycle.
- full_state  input  1  FSM is in the FIFO-full recovery state.
- dsize  output  3  payload byte count from the size byte.
- data_out  output  8  byte presented to the FIFO.
- destination  output  8  latched destination byte.
- crc_checked  output  1  checksum comparison done for the current packet.
- trusted_source  output  1  latched source is trusted.
- err  output  1  checksum or length mismatch in the current packet.

## Operation
- Internal registers:
  - source[7:0]
  - chk[7:0], the running XOR
  - cnt[2:0], payload bytes received
  - hold[7:0] and hold_valid, for a byte blocked by fifo_full
- Strobe priority if more than one is asserted: full_state > get_source > get_dest > store_header > get_size > load_data > get_crc.
- get_source & packet_valid_i:
  - source <= packet_in
  - trusted_source <= packet_in[7] (sources 0x80–0xFF are trusted)
  - chk, cnt, crc_checked, err, hold_valid all cleared
- get_dest & packet_valid_i: destination <= packet_in.
- store_header: data_out <= destination, forwarding the routing header to the FIFO. No packet_in capture.
- get_size & packet_valid_i: dsize <= packet_in[2:0]; packet_in[7:3] ignored.
- load_data & packet_valid_i:
  - chk <= chk ^ packet_in; cnt <= cnt + 1, wrapping at 8.
  - If !fifo_full: data_out <= packet_in.
  - If fifo_full: hold <= packet_in, hold_valid <= 1, data_out unchanged.
- full_state & !fifo_full & hold_valid: data_out <= hold, hold_valid <= 0. With fifo_full still high, nothing changes.
- get_crc & packet_valid_i:
  - crc_checked <= 1
  - err <= (packet_in != chk) | (cnt != dsize)
- No strobe, or strobe without packet_valid_i (where capture is required): all registers hold.
- crc_checked, err and trusted_source hold their values until the next get_source capture or reset.

## Timing
- All outputs are registered, with 1-cycle latency from the sampling edge.
- Reset values: dsize=0, data_out=0, destination=0, crc_checked=0, trusted_source=0, err=0. Internal registers are also 0.
- Reset overrides every strobe in the same cycle. Reset mid-packet discards the packet: a new packet begins only with get_source.
- Payload byte N is visible on data_out the cycle after its load_data edge, unless blocked by fifo_full.
- Back-to-back packets: get_crc in cycle k and get_source in cycle k+1 is legal. crc_checked/err are visible during cycle k+1, then clear after the k+1 edge.
- dsize=0 with zero load_data cycles is a legal, error-free packet if the CRC byte equals 0x00.

## Test plan
- Reset held 2 cycles with strobes active -> all outputs 0 throughout.
- Packet 1 sequence:
  - Steps: source 0x81, dest 0x0F, store_header, size 0x02, data 0xF0 then 0x0F, crc 0xFF.
  - Expected: trusted_source=1, destination=0x0F, data_out 0x0F after store_header, dsize=2, data_out 0xF0 then 0x0F, crc_checked=1, err=0.
- Packet 2, back-to-back:
  - Steps: source 0x18, dest 0x0A, size 0x03, data 0xF0, 0x0F, 0x3E, crc 0xFF.
  - Expected: on get_source, trusted_source=0 and crc_checked/err cleared; dsize=3; XOR is 0xC1, so after get_crc crc_checked=1 and err=1.
- Length mismatch: size 0x02 with three data bytes 0x01, 0x02, 0x04, crc 0x07 -> err=1 (cnt≠dsize), crc_checked=1.
- FIFO full:
  - Steps: assert fifo_full during data byte 0xA5, then full_state with fifo_full=0.
  - Expected: data_out unchanged during the blocked cycle, then 0xA5 one cycle after the full_state edge; the checksum still includes 0xA5.
- packet_valid_i=0 during get_dest/load_data -> destination, data_out, chk and cnt unchanged.
